// File: rtl/senone_stats_server.sv
// Streams the linear senone/component stats table from memory into a 2-entry tagged FIFO.
// Latency: first read the cycle after start, first entry valid 2 cycles after start.
// Backpressure: reads issue only with a free FIFO slot, so get_new_stats low stalls after 2 reads.
module senone_stats_server #(
  parameter int n_components = 25,
  parameter int n_senones    = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               get_new_stats,
  output logic signed [15:0] mean,
  output logic signed [15:0] omega,
  output logic signed [15:0] k,
  output logic               new_stats_available,
  output logic               first_comp,
  output logic               last_comp,
  output logic [7:0]         senone_index,
  output logic               mem_rd_en,
  output logic [12:0]        mem_addr,
  input  logic [47:0]        mem_rdata,
  output logic               busy,
  output logic               stats_done
);

  localparam int comp_w = (n_components > 1) ? $clog2(n_components) : 1;
  localparam logic [12:0] last_addr = 13'(n_components * n_senones - 1);
  localparam logic [comp_w-1:0] last_comp_idx = comp_w'(n_components - 1);
  localparam int tag_w = 2 + 8;
  localparam int entry_w = 48 + tag_w;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t              state;
  logic [12:0]         issue_addr;
  logic [comp_w-1:0]   comp_cnt;
  logic [7:0]          senone_cnt;
  logic                inflight;
  logic [tag_w-1:0]    issue_tag;
  logic [1:0]          fifo_count;
  logic [entry_w-1:0]  fifo_head;
  logic                pop;
  logic                can_issue;
  logic                first_tag;
  logic                last_tag;

  // Credit: a slot must be free once the in-flight word lands, counting this cycle's pop.
  assign pop       = new_stats_available & get_new_stats;
  assign can_issue = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign mem_rd_en = (state == STREAM) && can_issue;
  assign mem_addr  = issue_addr;
  assign busy       = (state != IDLE);
  assign stats_done = (state == DONE);
  assign new_stats_available = (fifo_count != 2'd0);
  assign first_tag = (comp_cnt == {comp_w{1'b0}});
  assign last_tag  = (comp_cnt == last_comp_idx);
  assign {mean, omega, k, first_comp, last_comp, senone_index} = fifo_head;

  sync_fifo #(
    .width (entry_w),
    .depth (2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data ({mem_rdata, issue_tag}),
    .rd_en   (get_new_stats),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      issue_addr <= '0;
      comp_cnt   <= '0;
      senone_cnt <= '0;
      inflight   <= 1'b0;
      issue_tag  <= '0;
    end else begin
      inflight <= mem_rd_en;
      // Tags travel alongside the read so they line up with the returning word.
      if (mem_rd_en) issue_tag <= {first_tag, last_tag, senone_cnt};
      case (state)
        IDLE: begin
          if (start) begin
            state      <= STREAM;
            issue_addr <= '0;
            comp_cnt   <= '0;
            senone_cnt <= '0;
          end
        end
        STREAM: begin
          if (mem_rd_en) begin
            issue_addr <= issue_addr + 13'd1;
            if (last_tag) begin
              comp_cnt   <= '0;
              senone_cnt <= senone_cnt + 8'd1;
            end else begin
              comp_cnt <= comp_cnt + 1'b1;
            end
            if (issue_addr == last_addr) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == 2'd0 && !inflight) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// Generic synchronous FIFO; depth must be a power of two, writer must respect count.
// Latency: written data visible at the head the cycle after the write.
// Backpressure: none internally; reads of an empty FIFO are ignored.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 2,
  parameter int cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic [cnt_w-1:0] count
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_senone_stats_server.sv
// Bench for senone_stats_server: full-rate, backpressure, random-ready, restart, mid-stream reset, small table.
module tb_senone_stats_server;
  localparam int NC = 25;
  localparam int NS = 256;
  localparam int TOTAL = NC * NS;
  localparam int SNC = 3;
  localparam int SNS = 2;
  localparam int STOTAL = SNC * SNS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic get_new_stats = 1'b0;
  logic signed [15:0] mean, omega, k;
  logic new_stats_available, first_comp, last_comp, mem_rd_en, busy, stats_done;
  logic [7:0] senone_index;
  logic [12:0] mem_addr;
  logic [47:0] mem_rdata;

  logic s_start = 1'b0;
  logic s_get = 1'b0;
  logic signed [15:0] s_mean, s_omega, s_k;
  logic s_avail, s_first, s_last, s_rd_en, s_busy, s_done;
  logic [7:0] s_senone;
  logic [12:0] s_addr;
  logic [47:0] s_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  senone_stats_server dut (
    .clk(clk), .reset(reset), .start(start), .get_new_stats(get_new_stats),
    .mean(mean), .omega(omega), .k(k), .new_stats_available(new_stats_available),
    .first_comp(first_comp), .last_comp(last_comp), .senone_index(senone_index),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .stats_done(stats_done)
  );

  senone_stats_server #(.n_components(SNC), .n_senones(SNS)) sdut (
    .clk(clk), .reset(reset), .start(s_start), .get_new_stats(s_get),
    .mean(s_mean), .omega(s_omega), .k(s_k), .new_stats_available(s_avail),
    .first_comp(s_first), .last_comp(s_last), .senone_index(s_senone),
    .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
    .busy(s_busy), .stats_done(s_done)
  );

  function automatic logic [47:0] word(int w);
    logic [15:0] v;
    v = 16'(w);
    return {v, ~v, v ^ 16'h5A5A};
  endfunction

  // Reference entry i of a table with nc components per senone.
  function automatic logic [57:0] exp_entry(int i, int nc);
    logic [15:0] v;
    v = 16'(i);
    return {v, ~v, v ^ 16'h5A5A, (i % nc) == 0, (i % nc) == nc - 1, 8'(i / nc)};
  endfunction

  function automatic logic [57:0] big_obs();
    return {mean, omega, k, first_comp, last_comp, senone_index};
  endfunction

  function automatic logic [57:0] small_obs();
    return {s_mean, s_omega, s_k, s_first, s_last, s_senone};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= word(int'(mem_addr));
    if (s_rd_en) s_rdata <= word(int'(s_addr));
  end

  task automatic tick(input logic g, input logic s);
    @(negedge clk);
    get_new_stats = g;
    start = s;
    #1;
  endtask

  task automatic do_start(input logic g);
    @(negedge clk);
    start = 1'b1;
    get_new_stats = g;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (big_obs() !== 58'd0) begin
      errors++; $display("FAIL reset_data: got %h, required 0", big_obs());
    end
    checks++;
    if ({new_stats_available, mem_rd_en, busy, stats_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got avail/rd/busy/done=%b, required 0000",
                         {new_stats_available, mem_rd_en, busy, stats_done});
    end
    checks++;
    if (mem_addr !== 13'd0) begin
      errors++; $display("FAIL reset_addr: got %0d, required 0", mem_addr);
    end
    checks++;
    if ({s_avail, s_rd_en, s_busy, s_done} !== 4'b0000 || small_obs() !== 58'd0) begin
      errors++; $display("FAIL reset_small: got ctrl=%b data=%h, required 0",
                         {s_avail, s_rd_en, s_busy, s_done}, small_obs());
    end
    reset = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if ({busy, mem_rd_en, new_stats_available} !== 3'b000) begin
      errors++; $display("FAIL idle_no_start: got busy/rd/avail=%b, required 000",
                         {busy, mem_rd_en, new_stats_available});
    end
  endtask

  task automatic test_full_rate();
    int idx = 0;
    int cyc = 0;
    int bubbles = 0;
    int dones = 0;
    do_start(1'b1);
    checks++;
    if (mem_rd_en !== 1'b1 || new_stats_available !== 1'b0 || mem_addr !== 13'd0) begin
      errors++; $display("FAIL full_first_read: got rd=%b avail=%b addr=%0d, required 1 0 0",
                         mem_rd_en, new_stats_available, mem_addr);
    end
    while (idx < TOTAL && cyc < TOTAL + 20) begin
      tick(1'b1, 1'b0);
      cyc++;
      if (stats_done) dones++;
      if (new_stats_available) begin
        checks++;
        if (big_obs() !== exp_entry(idx, NC)) begin
          errors++; $display("FAIL full_entry %0d: got %h, required %h", idx, big_obs(), exp_entry(idx, NC));
        end
        if (cyc != idx + 2) bubbles++;
        idx++;
      end
    end
    checks++;
    if (idx != TOTAL) begin
      errors++; $display("FAIL full_count: got %0d transfers, required %0d", idx, TOTAL);
    end
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL full_bubbles: got %0d off-cycle transfers, required 0", bubbles);
    end
    repeat (8) begin
      tick(1'b1, 1'b0);
      if (stats_done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL full_done: got %0d stats_done pulses, required 1", dones);
    end
    checks++;
    if (busy !== 1'b0 || new_stats_available !== 1'b0) begin
      errors++; $display("FAIL full_idle: got busy=%b avail=%b, required 0 0", busy, new_stats_available);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    int reads = 0;
    int unstable = 0;
    int dones = 0;
    do_start(1'b0);
    if (mem_rd_en) reads++;
    for (int c = 1; c < 10; c++) begin
      tick(1'b0, 1'b0);
      if (mem_rd_en) reads++;
      if (new_stats_available && big_obs() !== exp_entry(0, NC)) unstable++;
    end
    checks++;
    if (reads != 2) begin
      errors++; $display("FAIL bp_reads: got %0d reads, required 2", reads);
    end
    checks++;
    if (new_stats_available !== 1'b1 || mean !== 16'sd0) begin
      errors++; $display("FAIL bp_head: got avail=%b mean=%0d, required 1 0", new_stats_available, mean);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL bp_stable: got %0d changed cycles, required 0", unstable);
    end
    while (idx < TOTAL && cyc < 2 * TOTAL) begin
      tick(1'b1, 1'b0);
      cyc++;
      if (stats_done) dones++;
      if (new_stats_available) begin
        checks++;
        if (big_obs() !== exp_entry(idx, NC)) begin
          errors++; $display("FAIL bp_entry %0d: got %h, required %h", idx, big_obs(), exp_entry(idx, NC));
        end
        idx++;
      end
    end
    checks++;
    if (idx != TOTAL) begin
      errors++; $display("FAIL bp_count: got %0d transfers, required %0d", idx, TOTAL);
    end
    repeat (8) begin
      tick(1'b1, 1'b0);
      if (stats_done) dones++;
    end
    checks++;
    if (dones != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done: got %0d pulses busy=%b, required 1 0", dones, busy);
    end
  endtask

  task automatic test_random();
    int idx = 0;
    int cyc = 0;
    int occ = 0;
    int viol = 0;
    int occ_err = 0;
    int dones = 0;
    logic prev_rd;
    logic pop;
    logic g;
    do_start(1'b0);
    prev_rd = mem_rd_en;
    while (idx < TOTAL && cyc < 4 * TOTAL) begin
      g = 1'($urandom_range(0, 1));
      tick(g, 1'b0);
      cyc++;
      if (stats_done) dones++;
      if (new_stats_available !== (occ != 0)) occ_err++;
      pop = new_stats_available & get_new_stats;
      if (mem_rd_en && occ == 2 && !pop) viol++;
      if (pop) begin
        checks++;
        if (big_obs() !== exp_entry(idx, NC)) begin
          errors++; $display("FAIL rand_entry %0d: got %h, required %h", idx, big_obs(), exp_entry(idx, NC));
        end
        idx++;
      end
      occ = occ + int'(prev_rd) - int'(pop);
      prev_rd = mem_rd_en;
    end
    checks++;
    if (idx != TOTAL) begin
      errors++; $display("FAIL rand_count: got %0d transfers, required %0d", idx, TOTAL);
    end
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL rand_overissue: got %0d reads with full FIFO, required 0", viol);
    end
    checks++;
    if (occ_err != 0) begin
      errors++; $display("FAIL rand_occupancy: got %0d avail disagreements, required 0", occ_err);
    end
    repeat (8) begin
      tick(1'b0, 1'b0);
      if (stats_done) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL rand_done: got %0d pulses, required 1", dones);
    end
  endtask

  task automatic test_restart();
    int idx = 0;
    int cyc = 0;
    int dones = 0;
    logic s;
    do_start(1'b1);
    while (idx < TOTAL && cyc < 2 * TOTAL) begin
      s = (cyc == 40 || cyc == 3000 || cyc == TOTAL);
      tick(1'b1, s);
      cyc++;
      if (stats_done) dones++;
      if (new_stats_available) begin
        checks++;
        if (big_obs() !== exp_entry(idx, NC)) begin
          errors++; $display("FAIL restart_entry %0d: got %h, required %h", idx, big_obs(), exp_entry(idx, NC));
        end
        idx++;
      end
    end
    repeat (8) begin
      tick(1'b1, 1'b0);
      if (stats_done) dones++;
    end
    checks++;
    if (idx != TOTAL || dones != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL restart_summary: got %0d transfers %0d pulses busy=%b, required %0d 1 0",
                         idx, dones, busy, TOTAL);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    int cyc = 0;
    do_start(1'b1);
    while (idx < 100 && cyc < 200) begin
      tick(1'b1, 1'b0);
      cyc++;
      if (new_stats_available) idx++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (big_obs() !== 58'd0 || mem_addr !== 13'd0) begin
      errors++; $display("FAIL midreset_data: got %h addr=%0d, required 0 0", big_obs(), mem_addr);
    end
    checks++;
    if ({new_stats_available, mem_rd_en, busy, stats_done} !== 4'b0000) begin
      errors++; $display("FAIL midreset_ctrl: got %b, required 0000",
                         {new_stats_available, mem_rd_en, busy, stats_done});
    end
    tick(1'b1, 1'b0);
    checks++;
    if (new_stats_available !== 1'b0 || big_obs() !== 58'd0) begin
      errors++; $display("FAIL midreset_stale: got avail=%b data=%h, required 0 0", new_stats_available, big_obs());
    end
    do_start(1'b1);
    cyc = 0;
    while (!new_stats_available && cyc < 10) begin
      tick(1'b1, 1'b0);
      cyc++;
    end
    checks++;
    if (cyc != 2 || big_obs() !== exp_entry(0, NC) || first_comp !== 1'b1) begin
      errors++; $display("FAIL midreset_restart: got wait=%0d data=%h, required 2 %h", cyc, big_obs(), exp_entry(0, NC));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_small();
    int idx = 0;
    int cyc = 0;
    int dones = 0;
    @(negedge clk);
    s_start = 1'b1;
    s_get = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    while (idx < STOTAL && cyc < 100) begin
      @(negedge clk);
      s_get = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (s_done) dones++;
      if (s_avail && s_get) begin
        checks++;
        if (small_obs() !== exp_entry(idx, SNC)) begin
          errors++; $display("FAIL small_entry %0d: got %h, required %h", idx, small_obs(), exp_entry(idx, SNC));
        end
        idx++;
      end
    end
    checks++;
    if (idx != STOTAL) begin
      errors++; $display("FAIL small_count: got %0d transfers, required %0d", idx, STOTAL);
    end
    repeat (8) begin
      @(negedge clk);
      #1;
      if (s_done) dones++;
    end
    checks++;
    if (dones != 1 || s_busy !== 1'b0) begin
      errors++; $display("FAIL small_done: got %0d pulses busy=%b, required 1 0", dones, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random();
    test_restart();
    test_reset_mid();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/senone_stats_server.md
SENONE_STATS_SERVER -- requirements
Module: senone_stats_server

Interface
REQ-001 Parameter n_components, default 25, is the number of Gaussian components per senone.
REQ-002 Parameter n_senones, default 256, is the number of senones scored per observation vector.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-005 start  in  1  one-cycle pulse: a new observation vector is available, so stream the full stats table.
REQ-006 get_new_stats  in  1  consumer ready; an entry transfers on any cycle where get_new_stats and new_stats_available are both high.
REQ-007 mean, omega, k  out  16 each, signed (num)  stats of the head entry; valid while new_stats_available is high.
REQ-008 new_stats_available  out  1  the head entry is valid.
REQ-009 first_comp, last_comp  out  1 each  the head entry is component 0 or component n_components-1 of its senone.
REQ-010 senone_index  out  8  senone of the head entry.
REQ-011 mem_rd_en, mem_addr  out  1, 13  stats memory read request and word address.
REQ-012 mem_rdata  in  48  memory word, valid exactly 1 cycle after mem_rd_en; packing is [47:32] mean, [31:16] omega, [15:0] k.
REQ-013 busy, stats_done  out  1 each  busy is high outside IDLE; stats_done is a one-cycle pulse when the table is fully delivered.

Function
REQ-014 The stats table is linear: address = senone*n_components + comp, over the range 0 to n_components*n_senones-1 (0..6399 with the defaults).
REQ-015 The state machine has four states: IDLE, STREAM, DRAIN, DONE.
REQ-016 In IDLE, start moves the block to STREAM and clears the issue address, the component counter and the senone counter to 0.
REQ-017 In STREAM, a read is issued (mem_rd_en=1, mem_addr = issue address) when fifo_count + inflight - pop < 2.
  - pop is (new_stats_available & get_new_stats).
  - inflight is 1 if mem_rd_en was high in the previous cycle, else 0.
REQ-018 Each issued read increments the issue address; the component counter wraps from n_components-1 to 0 and then increments the senone counter.
REQ-019 Issuing the last address moves the block to DRAIN.
REQ-020 In DRAIN, once the FIFO is empty and inflight is 0, the block moves to DONE.
REQ-021 DONE lasts one cycle with stats_done=1, then the block returns to IDLE.
REQ-022 Returned words are written into a 2-entry FIFO together with first_comp, last_comp and senone_index tags captured at issue time.
REQ-023 The FIFO is never written while full; the credit rule in REQ-017 guarantees this.
REQ-024 A pop and a write in the same cycle keep fifo_count unchanged.
REQ-025 The output ports always present the FIFO head.
  - new_stats_available = (fifo_count != 0).
  - Output values are held stable while new_stats_available is high and get_new_stats is low.
REQ-026 Latency: with start sampled at edge E0, mem_rd_en is high in the cycle after E0, and new_stats_available is first high 2 cycles after E0.
REQ-027 Throughput: with get_new_stats held high, one entry transfers per cycle with no bubbles after the first.
REQ-028 start is ignored outside IDLE.
REQ-029 get_new_stats while the FIFO is empty has no effect.
REQ-030 Entries are delivered strictly in address order; none is dropped or duplicated.

Reset
REQ-031 Reset values: state IDLE, and all counters, fifo_count and inflight are 0.
REQ-032 Reset values: mem_rd_en=0, new_stats_available=0, busy=0, stats_done=0.
REQ-033 Reset values: mean=omega=k=0, first_comp=last_comp=0, senone_index=0, mem_addr=0.
REQ-034 Reset asserted mid-stream discards FIFO contents and any in-flight read; a mem_rdata word returning in the cycle after reset is not captured.

Verification
REQ-035 Full-rate stream: start, get_new_stats held high, memory word w holds mean=w, omega=~w, k=w^16'h5A5A -> 6400 transfers on consecutive cycles in order; first_comp on entries 0, 25, 50 and so on; last_comp on entries 24, 49 and so on; senone_index goes 0..255; stats_done pulses once; busy then falls.
REQ-036 Backpressure: get_new_stats low for 10 cycles after start -> exactly 2 reads issued, new_stats_available=1, mean=0 held stable; on release, addresses 0,1,2... are delivered with no loss.
REQ-037 Random get_new_stats toggling at 50% duty -> scoreboard matches 6400 entries in order, and mem_rd_en is never high while fifo_count=2 and pop=0.
REQ-038 start re-pulsed during STREAM -> ignored; the address sequence is unaffected and there is a single stats_done.
REQ-039 reset asserted at transfer 100 -> next cycle all outputs at reset values; a new start delivers from address 0 with first_comp=1.
REQ-040 n_components=3, n_senones=2 -> 6 entries; last_comp on entries 2 and 5; senone_index goes 0,0,0,1,1,1.
